debounced_updown_counter: RTL and testbench

- Parametrised successor to the single-button 16-bit push counter.
- Counts debounced press events from two raw pushbuttons (up, down) into a WIDTH-bit register. The register either wraps or saturates, selected by a mode parameter.
- Runs entirely on the 100 MHz system clock. A clock-enable tick replaces a divided clock, and debouncing is explicit rather than a side effect of slow sampling.
- Sits between the board buttons/switches and the LED or seven-segment display logic in top-level wrappers.

---
 rtl/debounced_updown_counter.sv | 126 ++++++++++++
 tb/tb_debounced_updown_counter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/debounced_updown_counter.sv
// Debounced up/down press counter.
// Two raw pushbuttons are synchronised, sampled on a slow clock-enable tick,
// debounced by requiring DB_SAMPLES consecutive differing samples, and their
// rising edges turned into one-cycle strobes. The strobes step a WIDTH-bit
// counter that either wraps or saturates at its limits.
module debounced_updown_counter #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int SAMPLE_HZ  = 1000,
    parameter int DB_SAMPLES = 8,
    parameter int WIDTH      = 16,
    parameter int WRAP       = 1
) (
    input  logic             CLK100MHZ,
    input  logic             RST,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
    output logic             up_pulse,
    output logic             down_pulse,
    output logic             at_max,
    output logic             at_min
);

    localparam int DIV   = CLK_HZ / SAMPLE_HZ;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SC_W  = (DB_SAMPLES > 1) ? $clog2(DB_SAMPLES) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(DB_SAMPLES - 1);
    localparam logic [WIDTH-1:0] CNT_MAX  = '1;

    // Channel 0 is the up button, channel 1 the down button.
    logic [1:0]            sync1_q, sync2_q;
    logic [1:0]            db_q, db_d;
    logic [1:0]            db_dly_q;
    logic [1:0][SC_W-1:0]  sc_q, sc_d;
    logic [1:0]            pulse_q, pulse_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic                  tick;
    logic [WIDTH-1:0]      count_q, count_d;

    // Sample-rate divider: tick marks the last cycle of each DIV-cycle period.
    always_comb begin
        tick  = (div_q == DIV_LAST);
        div_d = tick ? '0 : div_q + 1'b1;
    end

    // Debounce: accept a new level only after DB_SAMPLES differing ticks in a row.
    always_comb begin
        db_d = db_q;
        sc_d = sc_q;
        for (int i = 0; i < 2; i++) begin
            if (tick) begin
                if (sync2_q[i] != db_q[i]) begin
                    if (sc_q[i] == SC_LAST) begin
                        db_d[i] = sync2_q[i];
                        sc_d[i] = '0;
                    end else begin
                        sc_d[i] = sc_q[i] + 1'b1;
                    end
                end else begin
                    // An agreeing sample restarts qualification.
                    sc_d[i] = '0;
                end
            end
        end
    end

    // Press strobe: debounced level is high now but was low the cycle before.
    always_comb begin
        pulse_d = db_q & ~db_dly_q;
    end

    // Counter next state: clear wins, simultaneous presses cancel.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (pulse_q[0] && pulse_q[1]) begin
            count_d = count_q;
        end else if (pulse_q[0]) begin
            if (count_q == CNT_MAX && WRAP == 0) begin
                count_d = count_q;
            end else begin
                count_d = count_q + 1'b1;
            end
        end else if (pulse_q[1]) begin
            if (count_q == '0 && WRAP == 0) begin
                count_d = count_q;
            end else begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // State registers; reset aborts any qualification in progress.
    always_ff @(posedge CLK100MHZ) begin
        if (RST) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            db_q     <= '0;
            db_dly_q <= '0;
            sc_q     <= '0;
            pulse_q  <= '0;
            div_q    <= '0;
            count_q  <= '0;
        end else begin
            sync1_q  <= {btn_down, btn_up};
            sync2_q  <= sync1_q;
            db_q     <= db_d;
            db_dly_q <= db_q;
            sc_q     <= sc_d;
            pulse_q  <= pulse_d;
            div_q    <= div_d;
            count_q  <= count_d;
        end
    end

    assign count      = count_q;
    assign up_pulse   = pulse_q[0];
    assign down_pulse = pulse_q[1];
    assign at_max     = (count_q == CNT_MAX);
    assign at_min     = (count_q == '0);

endmodule

// File: tb/tb_debounced_updown_counter.sv
// Directed bench for debounced_updown_counter: one wrapping and one
// saturating instance share the same button, clear and reset stimulus.
module tb_debounced_updown_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, btn_up, btn_down, clear;
    logic [3:0] cnt_w, cnt_s;
    logic       upw, dnw, maxw, minw;
    logic       ups, dns, maxs, mins;

    int checks = 0;
    int errors = 0;
    int up_cnt = 0;
    int dn_cnt = 0;
    int both_cnt = 0;

    debounced_updown_counter #(
        .CLK_HZ(1000), .SAMPLE_HZ(100), .DB_SAMPLES(4), .WIDTH(4), .WRAP(1)
    ) u_w (
        .CLK100MHZ(clk), .RST(rst), .btn_up(btn_up), .btn_down(btn_down),
        .clear(clear), .count(cnt_w), .up_pulse(upw), .down_pulse(dnw),
        .at_max(maxw), .at_min(minw)
    );

    debounced_updown_counter #(
        .CLK_HZ(1000), .SAMPLE_HZ(100), .DB_SAMPLES(4), .WIDTH(4), .WRAP(0)
    ) u_s (
        .CLK100MHZ(clk), .RST(rst), .btn_up(btn_up), .btn_down(btn_down),
        .clear(clear), .count(cnt_s), .up_pulse(ups), .down_pulse(dns),
        .at_max(maxs), .at_min(mins)
    );

    // Pulse tally on the wrapping instance, sampled mid-cycle.
    always @(negedge clk) begin
        if (upw) up_cnt++;
        if (dnw) dn_cnt++;
        if (upw && dnw) both_cnt++;
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Hold the given buttons long enough to qualify, then release long enough
    // for the release to qualify as well.
    task automatic press(input logic u, input logic d);
        btn_up   = u;
        btn_down = d;
        repeat (60) @(negedge clk);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        repeat (60) @(negedge clk);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        repeat (2) @(negedge clk);
        clear = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int base;
        int found;
        int lat;
        int pk;

        rst = 1'b1; btn_up = 1'b0; btn_down = 1'b0; clear = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_count_w", int'(cnt_w), 0);
        check("rst_min_w",   int'(minw), 1);
        check("rst_max_w",   int'(maxw), 0);
        check("rst_up_w",    int'(upw), 0);
        check("rst_dn_w",    int'(dnw), 0);
        check("rst_count_s", int'(cnt_s), 0);
        check("rst_min_s",   int'(mins), 1);
        check("rst_max_s",   int'(maxs), 0);

        // Tick cadence: first tick in the 10th cycle after release, then every 10
        rst = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            check($sformatf("tick_c%0d", k), int'(u_w.tick), (k % 10 == 0) ? 1 : 0);
            @(negedge clk);
        end

        // Clean press
        base = up_cnt;
        btn_up = 1'b1;
        found = 0;
        lat = 0;
        for (int k = 1; k <= 60 && found == 0; k++) begin
            @(negedge clk);
            if (upw) begin
                found = 1;
                lat = k;
            end
        end
        check("clean_seen", found, 1);
        check("clean_latency_window", (lat >= 30 && lat <= 50) ? 1 : 0, 1);
        check("clean_count_during_pulse", int'(cnt_w), 0);
        @(negedge clk);
        check("clean_count_after", int'(cnt_w), 1);
        check("clean_pulse_one_cycle", int'(upw), 0);
        repeat (40) @(negedge clk);
        btn_up = 1'b0;
        repeat (60) @(negedge clk);
        check("clean_single_pulse", up_cnt - base, 1);
        check("clean_count_s", int'(cnt_s), 1);

        // Bounce rejection
        base = up_cnt;
        repeat (5) begin
            btn_up = 1'b1;
            repeat (25) @(negedge clk);
            btn_up = 1'b0;
            repeat (12) @(negedge clk);
        end
        repeat (60) @(negedge clk);
        check("bounce_no_pulse", up_cnt - base, 0);
        check("bounce_count", int'(cnt_w), 1);
        press(1'b1, 1'b0);
        check("bounce_then_steady", up_cnt - base, 1);
        check("bounce_steady_count_w", int'(cnt_w), 2);
        check("bounce_steady_count_s", int'(cnt_s), 2);

        // Boundary behaviour: wrap vs saturate
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 1; i <= 16; i++) begin
            press(1'b1, 1'b0);
            check($sformatf("up%0d_w", i), int'(cnt_w), i % 16);
            check($sformatf("up%0d_s", i), int'(cnt_s), (i > 15) ? 15 : i);
            if (i == 15) begin
                check("max_flag_w", int'(maxw), 1);
                check("max_flag_s", int'(maxs), 1);
            end
        end
        check("wrap_min_flag_w", int'(minw), 1);
        check("sat_max_flag_s", int'(maxs), 1);
        press(1'b0, 1'b1);
        check("down_wrap_w", int'(cnt_w), 15);
        check("down_sat_s", int'(cnt_s), 14);
        pulse_clear();
        check("clear_w", int'(cnt_w), 0);
        check("clear_s", int'(cnt_s), 0);
        press(1'b0, 1'b1);
        check("down_from0_w", int'(cnt_w), 15);
        check("down_from0_max_w", int'(maxw), 1);
        check("down_from0_s", int'(cnt_s), 0);
        check("down_from0_min_s", int'(mins), 1);

        // Simultaneous presses cancel
        pulse_clear();
        repeat (5) press(1'b1, 1'b0);
        check("five_w", int'(cnt_w), 5);
        base = both_cnt;
        press(1'b1, 1'b1);
        check("both_coincide", both_cnt - base, 1);
        check("both_count_w", int'(cnt_w), 5);
        check("both_count_s", int'(cnt_s), 5);

        // Press qualifying during clear is discarded
        repeat (4) press(1'b1, 1'b0);
        check("nine_w", int'(cnt_w), 9);
        clear = 1'b1;
        base = up_cnt;
        btn_up = 1'b1;
        repeat (60) @(negedge clk);
        check("clear_press_qualified", up_cnt - base, 1);
        check("clear_hold_count_w", int'(cnt_w), 0);
        btn_up = 1'b0;
        repeat (60) @(negedge clk);
        clear = 1'b0;
        repeat (30) @(negedge clk);
        check("clear_after_w", int'(cnt_w), 0);
        check("clear_after_s", int'(cnt_s), 0);
        check("clear_no_replay", up_cnt - base, 1);

        // Reset in the middle of qualification with the button held
        btn_up = 1'b1;
        repeat (25) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        base = up_cnt;
        pk = 0;
        for (int k = 1; k <= 60; k++) begin
            if (upw && pk == 0) pk = k;
            @(negedge clk);
        end
        check("rstmid_pulse_cycle", pk, 42);
        check("rstmid_count_w", int'(cnt_w), 1);
        repeat (40) @(negedge clk);
        check("rstmid_single_pulse", up_cnt - base, 1);
        btn_up = 1'b0;
        repeat (60) @(negedge clk);
        check("rstmid_release_count_s", int'(cnt_s), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
